// File: rtl/multdiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_seq_if
// Purpose  : Request/response bundle between the execute stage and the
//            sequential multiply/divide unit.
// Signals  : data_operandA/B  [31:0] operands (sampled on a start edge)
//            ctrl_MULT/ctrl_DIV      one-cycle start pulses
//            data_result      [31:0] product low word or quotient
//            data_exception          overflow / divide-by-zero flag
//            data_resultRDY          one-cycle result-valid pulse
//            busy                    operation in flight
// Modports : master (execute stage), slave (multdiv_seq)
// Revision : 1.0  initial release
// ============================================================================
interface multdiv_seq_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_seq
// Purpose  : Sequential signed 32-bit multiply (radix-2 Booth) and divide
//            (restoring, on magnitudes) with a fixed 33-cycle latency from
//            the start edge to the one-cycle data_resultRDY pulse.
// Ports    : clock  - rising-edge clock
//            reset  - asynchronous active-low reset
//            mdu    - multdiv_seq_if.slave (operands, start pulses, result,
//                     exception, ready pulse, busy)
// Config   : MULTDIV_DIV_EN - when defined the divide datapath is built;
//            when undefined a divide request still takes 33 cycles and
//            returns result 0 with the exception flag set.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_seq (
    input  wire          clock,
    input  wire          reset,
    multdiv_seq_if.slave mdu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd32;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    // Booth: acc holds the (sign-extended) upper product half, lo the lower
    // half / remaining multiplier bits, qm1 the Booth guard bit.
    // Divide: acc holds the partial remainder, lo the dividend/quotient.
    logic [32:0] acc_q,   acc_d;
    logic [31:0] lo_q,    lo_d;
    logic        qm1_q,   qm1_d;
    logic [31:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic [31:0] result_q, result_d;
    logic        exc_q,   exc_d;

    logic        w_start;
    logic [32:0] w_mext;
    logic [32:0] w_booth_sum;

`ifdef MULTDIV_DIV_EN
    logic        neg_q,  neg_d;      // quotient must be negated at DONE
    logic        div0_q, div0_d;
    logic        ovf_q,  ovf_d;      // 0x80000000 / -1
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_trial;
    logic        w_div_bit;

    assign w_abs_a     = mdu.data_operandA[31] ? (~mdu.data_operandA + 32'd1)
                                               : mdu.data_operandA;
    assign w_abs_b     = mdu.data_operandB[31] ? (~mdu.data_operandB + 32'd1)
                                               : mdu.data_operandB;
    // The remainder is always below the divisor (<= 2^31), so dropping
    // acc_q[32] on the shift never loses information.
    assign w_div_shift = {acc_q[31:0], lo_q[31]};
    assign w_div_trial = w_div_shift - {1'b0, mcand_q};
    assign w_div_bit   = ~w_div_trial[32];
`endif

    assign w_start = mdu.ctrl_MULT | mdu.ctrl_DIV;

    // Booth step: {lo[0], qm1} = 10 subtracts, 01 adds the multiplicand.
    // A 33-bit accumulator keeps -(-2^31) representable.
    always_comb begin
        w_mext      = {mcand_q[31], mcand_q};
        w_booth_sum = acc_q;
        if (lo_q[0] & ~qm1_q) begin
            w_booth_sum = acc_q - w_mext;
        end else if (~lo_q[0] & qm1_q) begin
            w_booth_sum = acc_q + w_mext;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            mcand_q  <= '0;
            is_div_q <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            mcand_q  <= mcand_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
            exc_q    <= exc_d;
`ifdef MULTDIV_DIV_EN
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        mcand_d  = mcand_q;
        is_div_d = is_div_q;
        result_d = result_q;
        exc_d    = exc_q;
`ifdef MULTDIV_DIV_EN
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
`endif

        if (w_start) begin
            // A start in any state restarts; an aborted op never reaches DONE.
            state_d  = S_RUN;
            cnt_d    = '0;
            acc_d    = '0;
            qm1_d    = 1'b0;
            is_div_d = ~mdu.ctrl_MULT;    // MULT wins when both are high
            mcand_d  = mdu.data_operandA;
            lo_d     = mdu.data_operandB;
`ifdef MULTDIV_DIV_EN
            if (!mdu.ctrl_MULT) begin
                mcand_d = w_abs_b;
                lo_d    = w_abs_a;
                neg_d   = mdu.data_operandA[31] ^ mdu.data_operandB[31];
                div0_d  = (mdu.data_operandB == 32'd0);
                ovf_d   = (mdu.data_operandA == 32'h8000_0000) &&
                          (mdu.data_operandB == 32'hFFFF_FFFF);
            end
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    if (cnt_q == c_LAST_ITER) begin
                        // Extra cycle after the last iteration: fix signs
                        // and register the result for the DONE pulse.
                        state_d = S_DONE;
                        if (is_div_q) begin
`ifdef MULTDIV_DIV_EN
                            if (div0_q) begin
                                result_d = '0;
                                exc_d    = 1'b1;
                            end else begin
                                result_d = neg_q ? (~lo_q + 32'd1) : lo_q;
                                exc_d    = ovf_q;
                            end
`else
                            result_d = '0;
                            exc_d    = 1'b1;
`endif
                        end else begin
                            result_d = lo_q;
                            exc_d    = (acc_q[31:0] != {32{lo_q[31]}});
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
`ifdef MULTDIV_DIV_EN
                        if (is_div_q) begin
                            acc_d = w_div_bit ? w_div_trial : w_div_shift;
                            lo_d  = {lo_q[30:0], w_div_bit};
                        end else begin
                            acc_d = {w_booth_sum[32], w_booth_sum[32:1]};
                            lo_d  = {w_booth_sum[0], lo_q[31:1]};
                            qm1_d = lo_q[0];
                        end
`else
                        // Divide requests also cycle through here; their
                        // intermediate values are discarded at DONE.
                        acc_d = {w_booth_sum[32], w_booth_sum[32:1]};
                        lo_d  = {w_booth_sum[0], lo_q[31:1]};
                        qm1_d = lo_q[0];
`endif
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign mdu.data_result    = result_q;
    assign mdu.data_exception = exc_q;
    assign mdu.data_resultRDY = (state_q == S_DONE);
    assign mdu.busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_seq
// Purpose  : Self-checking bench for multdiv_seq; honours MULTDIV_DIV_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multdiv_seq_if mdu();

    multdiv_seq dut (
        .clock (clock),
        .reset (reset),
        .mdu   (mdu)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model(input bit div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        logic signed [63:0] p;
        if (!div) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r = p[31:0];
            e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        end else begin
`ifdef MULTDIV_DIV_EN
            if (b == 32'd0) begin
                r = 32'd0; e = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = 32'h8000_0000; e = 1'b1;
            end else begin
                r = $signed(a) / $signed(b); e = 1'b0;
            end
`else
            r = 32'd0; e = 1'b1;
`endif
        end
    endfunction

    // Scoreboard: when a result is due, and what the outputs must hold.
    int          cyc      = 0;
    bit          pend     = 1'b0;
    int          due      = 0;
    logic [31:0] nxt_res  = '0;
    logic        nxt_exc  = 1'b0;
    logic [31:0] held_res = '0;
    logic        held_exc = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend     = 1'b0;
            held_res = '0;
            held_exc = 1'b0;
        end else begin
            cyc++;
            if (mdu.ctrl_MULT || mdu.ctrl_DIV) begin
                pend = 1'b1;
                due  = cyc + 33;
                model(!mdu.ctrl_MULT, mdu.data_operandA, mdu.data_operandB, nxt_res, nxt_exc);
            end else begin
                if (pend && cyc == due) begin
                    held_res = nxt_res;
                    held_exc = nxt_exc;
                end
                if (pend && cyc > due) pend = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        chk("sb_rdy",    {63'd0, mdu.data_resultRDY}, {63'd0, (pend && cyc == due)});
        chk("sb_busy",   {63'd0, mdu.busy},           {63'd0, pend});
        chk("sb_result", {32'd0, mdu.data_result},    {32'd0, held_res});
        chk("sb_exc",    {63'd0, mdu.data_exception}, {63'd0, held_exc});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Call at #1 after a rising edge; start is sampled at the next edge.
    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input string name);
        int k;
        bit seen;
        mdu.ctrl_MULT = m; mdu.ctrl_DIV = d;
        mdu.data_operandA = a; mdu.data_operandB = b;
        tick(1);
        mdu.ctrl_MULT = 1'b0; mdu.ctrl_DIV = 1'b0;
        mdu.data_operandA = $urandom; mdu.data_operandB = $urandom;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            tick(1);
            k++;
            seen = mdu.data_resultRDY;
        end
        chk({name, "_latency"}, 64'(k), 64'd33);
        chk({name, "_result"}, {31'd0, mdu.data_result, mdu.data_exception}, {31'd0, er, ee});
    endtask

    logic [31:0] pr;
    logic        pe;
    logic [31:0] corner [6];
    int          rdy_seen;

    initial begin
        mdu.ctrl_MULT = 1'b0; mdu.ctrl_DIV = 1'b0;
        mdu.data_operandA = '0; mdu.data_operandB = '0;
        corner[0] = 32'd0;         corner[1] = 32'd1;
        corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF; corner[5] = 32'd7;

        // Pin the reference model with hand-computed values.
        model(0, 32'd6, 32'd7, pr, pe);                         chk("pin_mul_6x7",   {31'd0, pr, pe}, {31'd0, 32'h2A, 1'b0});
        model(0, 32'hFFFF_FFFD, 32'd5, pr, pe);                 chk("pin_mul_neg",   {31'd0, pr, pe}, {31'd0, 32'hFFFF_FFF1, 1'b0});
        model(0, 32'h0001_0000, 32'h0001_0000, pr, pe);         chk("pin_mul_ovf",   {31'd0, pr, pe}, {31'd0, 32'h0, 1'b1});
`ifdef MULTDIV_DIV_EN
        model(1, 32'hFFFF_FF9C, 32'd7, pr, pe);                 chk("pin_div_neg",   {31'd0, pr, pe}, {31'd0, 32'hFFFF_FFF2, 1'b0});
`else
        model(1, 32'hFFFF_FF9C, 32'd7, pr, pe);                 chk("pin_div_off",   {31'd0, pr, pe}, {31'd0, 32'h0, 1'b1});
`endif

        // Reset state
        #2 reset = 1'b0;
        tick(3);
        chk("rst_result", {32'd0, mdu.data_result}, 64'd0);
        chk("rst_exc",    {63'd0, mdu.data_exception}, 64'd0);
        chk("rst_rdy",    {63'd0, mdu.data_resultRDY}, 64'd0);
        chk("rst_busy",   {63'd0, mdu.busy}, 64'd0);
        reset = 1'b1;
        tick(2);

        run_op(1, 0, 32'd6,          32'd7,          32'h0000_002A, 1'b0, "mul_6x7");
        run_op(1, 0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 1'b0, "mul_neg");
        run_op(1, 0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1'b1, "mul_ovf");
`ifdef MULTDIV_DIV_EN
        run_op(0, 1, 32'd100,        32'd7,          32'd14,        1'b0, "div_100_7");
        run_op(0, 1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 1'b0, "div_neg");
        run_op(0, 1, 32'd5,          32'd0,          32'd0,         1'b1, "div_by0");
        run_op(0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, "div_ovf");
`else
        run_op(0, 1, 32'd100,        32'd7,          32'd0,         1'b1, "div_off");
        run_op(0, 1, 32'd5,          32'd0,          32'd0,         1'b1, "div_by0");
        run_op(0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1'b1, "div_ovf");
`endif

        // Abort: 3x3, then 4x4 ten cycles later
        mdu.ctrl_MULT = 1'b1; mdu.data_operandA = 32'd3; mdu.data_operandB = 32'd3;
        tick(1);
        mdu.ctrl_MULT = 1'b0;
        tick(9);
        run_op(1, 0, 32'd4, 32'd4, 32'd16, 1'b0, "abort_4x4");
        run_op(1, 1, 32'd6, 32'd2, 32'd12, 1'b0, "both_6x2");

        // Reset in the middle of a multiply
        mdu.ctrl_MULT = 1'b1; mdu.data_operandA = 32'd7; mdu.data_operandB = 32'd9;
        tick(1);
        mdu.ctrl_MULT = 1'b0;
        tick(14);
        #3 reset = 1'b0;
        #1;
        chk("midrst_result", {32'd0, mdu.data_result}, 64'd0);
        chk("midrst_exc",    {63'd0, mdu.data_exception}, 64'd0);
        chk("midrst_rdy",    {63'd0, mdu.data_resultRDY}, 64'd0);
        chk("midrst_busy",   {63'd0, mdu.busy}, 64'd0);
        tick(3);
        reset = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (mdu.data_resultRDY) rdy_seen++;
        end
        chk("midrst_no_rdy", 64'(rdy_seen), 64'd0);
        run_op(1, 0, 32'd2, 32'd9, 32'd18, 1'b0, "post_rst_2x9");

        // Random traffic: idle gaps, aborts, back-to-back starts
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            mdu.ctrl_MULT = (sel < 5) || (sel == 8);
            mdu.ctrl_DIV  = (sel >= 4) && (sel <= 8);
            mdu.data_operandA = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            mdu.data_operandB = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            tick(1);
            mdu.ctrl_MULT = 1'b0; mdu.ctrl_DIV = 1'b0;
            mdu.data_operandA = $urandom; mdu.data_operandB = $urandom;
            tick(int'($urandom_range(0, 38)));
        end
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
